mem_dump_tx: RTL and testbench

- Outbound counterpart of the UART load path, which writes received words into instruction/data memory.
- On a start request, reads a block of 32-bit words from data memory starting at a given byte address.
- Serializes each word into 4 bytes, least-significant byte first, and streams them to the UART byte transmitter over a valid/ready handshake.
- Used to dump results and the data section back to the host after a run.

---
 rtl/mem_dump_pkg.sv | 21 ++
 rtl/mem_dump_tx_if.sv | 34 +++
 rtl/mem_dump_tx_word_serializer.sv | 46 ++++
 rtl/mem_dump_tx.sv | 111 +++++++++++
 tb/tb_mem_dump_tx.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_dump_pkg.sv
// Shared definitions for the memory dump path: FSM states, word geometry and
// the default dump origin used by both the loader and the dump transmitter.
package mem_dump_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = BYTES_PER_WORD * 8;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  localparam logic [31:0] DATA_SECTION_BASE_ADDR = 32'h0001_0000;

endpackage

// File: rtl/mem_dump_tx_if.sv
// Bundle of the dump control, memory read and byte transmit signals.
// tx handshake: a byte moves when tx_valid && tx_ready; once tx_valid rises it
// stays high with tx_data stable until that cycle. rd_valid answers one rd_req.
interface mem_dump_tx_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              busy;
  logic              done;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              rd_valid;

  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    input  start, base_addr, word_count, rd_data, rd_valid, tx_ready,
    output busy, done, rd_req, rd_addr, tx_data, tx_valid
  );

  modport slave (
    output start, base_addr, word_count, rd_data, rd_valid, tx_ready,
    input  busy, done, rd_req, rd_addr, tx_data, tx_valid
  );

endinterface

// File: rtl/mem_dump_tx_word_serializer.sv
// Holds one 32-bit word and emits it as 4 bytes, LSB first, under valid/ready.
// last_o marks the cycle in which the final byte of the word is accepted.
module word_serializer
  import mem_dump_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              last_o
);

  logic [WORD_W-1:0]     shift_q;
  logic [BYTE_IDX_W-1:0] idx_q;
  logic                  valid_q;
  logic                  accept;

  assign accept = valid_q && tx_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      shift_q <= word_i;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (accept) begin
      // The next byte always sits in the low 8 bits, so tx_data is a plain register tap.
      shift_q <= {8'h00, shift_q[WORD_W-1:8]};
      idx_q   <= idx_q + BYTE_IDX_W'(1);
      if (idx_q == LAST_BYTE_IDX) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign tx_data_o  = shift_q[7:0];
  assign tx_valid_o = valid_q;
  assign last_o     = accept && (idx_q == LAST_BYTE_IDX);

endmodule

// File: rtl/mem_dump_tx.sv
// Streams a block of data-memory words to the UART byte transmitter, one read
// outstanding at a time; the FSM owns the address and remaining-word counters.
module mem_dump_tx
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16,
  parameter int STRIDE = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_dump_tx_if.master bus,
  output state_t        state_o
);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_req_q;
  logic [ADDR_W-1:0] rd_addr_q;

  logic [ADDR_W-1:0] addr_next;
  logic              ser_load;
  logic              ser_last;

  // Wraps silently at 2^ADDR_W.
  assign addr_next = addr_q + ADDR_W'(STRIDE);
  assign ser_load  = (state_q == WAIT) && bus.rd_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      rd_req_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            addr_q      <= bus.base_addr;
            remaining_q <= bus.word_count;
            busy_q      <= 1'b1;
            if (bus.word_count == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q   <= REQ;
              rd_req_q  <= 1'b1;
              rd_addr_q <= bus.base_addr;
            end
          end
        end
        REQ: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.rd_valid) begin
            state_q <= SEND;
          end
        end
        SEND: begin
          if (ser_last) begin
            addr_q      <= addr_next;
            remaining_q <= remaining_q - CNT_W'(1);
            // Decide on the pre-decrement count so REQ/FIN outputs can be registered now.
            if (remaining_q != CNT_W'(1)) begin
              state_q   <= REQ;
              rd_req_q  <= 1'b1;
              rd_addr_q <= addr_next;
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  word_serializer u_ser (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ser_load),
    .word_i     (bus.rd_data),
    .tx_data_o  (bus.tx_data),
    .tx_valid_o (bus.tx_valid),
    .tx_ready_i (bus.tx_ready),
    .last_o     (ser_last)
  );

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_req  = rd_req_q;
  assign bus.rd_addr = rd_addr_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Bench for mem_dump_tx: memory responder with configurable latency, random
// tx_ready back-pressure, and a byte/address scoreboard fed by a word-level model.
`timescale 1ns/1ps
module tb_mem_dump_tx;
  import mem_dump_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_dump_tx_if #(.ADDR_W(32), .CNT_W(16)) bus ();
  state_t dbg_state;

  mem_dump_tx #(.ADDR_W(32), .CNT_W(16), .STRIDE(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory model and responder ----------------
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return ~a;
  endfunction

  int          lat_cfg = 2;
  int          pending = 0;
  logic [31:0] pend_addr = '0;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        stale_valid = 1'b0;

  assign bus.rd_valid = resp_valid | stale_valid;
  assign bus.rd_data  = stale_valid ? 32'hBAD0_BAD0 : resp_data;

  always @(posedge clk) begin
    #2;
    resp_valid = 1'b0;
    if (rst) begin
      pending = 0;
    end else begin
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          resp_valid = 1'b1;
          resp_data  = mem_read(pend_addr);
        end
      end
      if (bus.rd_req) begin
        pending   = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
        pend_addr = bus.rd_addr;
      end
    end
  end

  int ready_mode = 0;
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       bus.tx_ready = 1'b1;
      1:       bus.tx_ready = 1'($urandom_range(0, 1));
      default: bus.tx_ready = 1'b0;
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  logic [7:0]  exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] rd_log[$];
  int          acc_cyc[$];
  int          done_cnt = 0;
  int          acc_cnt = 0;
  int          txv_cnt = 0;
  int          done_cyc = -1;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 64'(bus.tx_valid), 64'd1);
        check("stall_data_held", 64'(bus.tx_data), 64'(prev_data));
      end
      if (bus.tx_valid) txv_cnt++;
      if (bus.tx_valid && bus.tx_ready) begin
        acc_cnt++;
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL byte_extra: got %02h with no byte expected (cycle %0d)", bus.tx_data, cyc);
        end else begin
          check("tx_byte", 64'(bus.tx_data), 64'(exp_q.pop_front()));
        end
      end
      if (bus.rd_req) rd_log.push_back(bus.rd_addr);
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Expected traffic straight from the dump rules: word i lives at base+4i, bytes LSB first.
  task automatic model_push(input logic [31:0] base, input logic [15:0] cnt);
    logic [31:0] a;
    logic [31:0] w;
    for (int i = 0; i < int'(cnt); i++) begin
      a = base + 32'(i) * 32'd4;
      w = mem_read(a);
      exp_addr_q.push_back(a);
      for (int j = 0; j < 4; j++) exp_q.push_back(w[8*j +: 8]);
    end
  endtask

  task automatic fill_mem(input logic [31:0] base, input int cnt);
    for (int i = 0; i < cnt; i++) mem[base + 32'(i) * 32'd4] = $urandom;
  endtask

  task automatic clear_logs();
    rd_log.delete();
    acc_cyc.delete();
    done_cnt = 0;
    acc_cnt  = 0;
    txv_cnt  = 0;
    done_cyc = -1;
  endtask

  int start_cyc = 0;
  task automatic pulse_start(input logic [31:0] base, input logic [15:0] cnt);
    bus.base_addr  = base;
    bus.word_count = cnt;
    bus.start      = 1'b1;
    start_cyc      = cyc;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit poke);
    int n = 0;
    bit poked = 1'b0;
    while (bus.done !== 1'b1 && n < budget) begin
      if (poke && !poked && bus.tx_valid) begin
        bus.base_addr  = 32'h0000_5000;
        bus.word_count = 16'd5;
        bus.start      = 1'b1;
        poked          = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      n++;
    end
    bus.start = 1'b0;
    check("done_seen", 64'(bus.done), 64'd1);
    if (poke) check("poke_issued", 64'(poked), 64'd1);
  endtask

  task automatic do_dump(input logic [31:0] base, input logic [15:0] cnt, input bit poke,
                         input bit done_poke);
    int n;
    clear_logs();
    model_push(base, cnt);
    pulse_start(base, cnt);
    wait_done(200 + 60 * int'(cnt), poke);
    if (done_poke) begin
      bus.base_addr  = 32'h0000_6000;
      bus.word_count = 16'd1;
      bus.start      = 1'b1;
    end
    tick();
    bus.start = 1'b0;
    check("busy_after_done", 64'(bus.busy), 64'd0);
    check("done_one_cycle", 64'(bus.done), 64'd0);
    tick();
    tick();
    check("rd_req_quiet", 64'(bus.rd_req), 64'd0);
    check("bytes_remaining", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check("done_count", 64'(done_cnt), 64'd1);
    check("read_count", 64'(rd_log.size()), 64'(exp_addr_q.size()));
    n = (rd_log.size() < exp_addr_q.size()) ? rd_log.size() : exp_addr_q.size();
    for (int i = 0; i < n; i++) check("rd_addr", 64'(rd_log[i]), 64'(exp_addr_q[i]));
    exp_addr_q.delete();
  endtask

  typedef struct {
    logic [31:0] base;
    logic [15:0] count;
    int          lat;
    int          rmode;
    int          exp_reads;
    int          exp_bytes;
    logic [31:0] exp_last_addr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #(500_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int          n;
    int          tv;
    int          dc;
    int          rl;
    logic [31:0] w;
    logic [31:0] r;
    logic [31:0] base;
    logic [15:0] cnt;

    vecs[0] = '{32'h0001_0000, 16'd1, 2, 0, 1, 4,  32'h0001_0000};
    vecs[1] = '{32'h0001_0000, 16'd3, 1, 1, 3, 12, 32'h0001_0008};
    vecs[2] = '{32'hFFFF_FFFC, 16'd2, 3, 0, 2, 8,  32'h0000_0000};
    vecs[3] = '{32'h0000_0100, 16'd0, 1, 0, 0, 0,  32'h0000_0000};
    vecs[4] = '{32'h7FFF_FFF8, 16'd4, 1, 1, 4, 16, 32'h8000_0004};

    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.word_count = '0;
    #1 rst = 1'b1;
    repeat (3) tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_rd_req", 64'(bus.rd_req), 64'd0);
    check("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("rst_tx_data", 64'(bus.tx_data), 64'd0);
    check("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;
    tick();

    // Single word, ready always high, fixed 2-cycle read latency.
    mem[DATA_SECTION_BASE_ADDR] = 32'h4433_2211;
    lat_cfg    = 2;
    ready_mode = 0;
    clear_logs();
    model_push(DATA_SECTION_BASE_ADDR, 16'd1);
    pulse_start(DATA_SECTION_BASE_ADDR, 16'd1);
    check("c1_busy", 64'(bus.busy), 64'd1);
    check("c1_rd_req", 64'(bus.rd_req), 64'd1);
    check("c1_rd_addr", 64'(bus.rd_addr), 64'h1_0000);
    wait_done(100, 1'b0);
    check("first_byte_cycle", 64'(acc_cyc.size() > 0 ? acc_cyc[0] : -1), 64'(start_cyc + 4));
    check("last_byte_cycle", 64'(acc_cyc.size() == 4 ? acc_cyc[3] : -1), 64'(start_cyc + 7));
    check("done_cycle", 64'(done_cyc), 64'(start_cyc + 8));
    tick();
    check("single_busy_low", 64'(bus.busy), 64'd0);
    check("single_bytes_left", 64'(exp_q.size()), 64'd0);
    check("single_reads", 64'(rd_log.size()), 64'd1);
    exp_q.delete();
    exp_addr_q.delete();

    // Three words with random stalls and random read latency.
    mem[32'h0001_0000] = 32'hA0A1_A2A3;
    mem[32'h0001_0004] = 32'hB0B1_B2B3;
    mem[32'h0001_0008] = 32'hC0C1_C2C3;
    lat_cfg    = 0;
    ready_mode = 1;
    do_dump(32'h0001_0000, 16'd3, 1'b0, 1'b0);
    check("three_byte_total", 64'(acc_cnt), 64'd12);

    // Zero-length dump.
    ready_mode = 0;
    clear_logs();
    pulse_start(32'h0000_0300, 16'd0);
    check("zero_busy_c1", 64'(bus.busy), 64'd1);
    check("zero_done_c1", 64'(bus.done), 64'd1);
    check("zero_rd_req_c1", 64'(bus.rd_req), 64'd0);
    tick();
    check("zero_busy_c2", 64'(bus.busy), 64'd0);
    check("zero_done_c2", 64'(bus.done), 64'd0);
    tick();
    check("zero_no_tx", 64'(txv_cnt), 64'd0);
    check("zero_no_reads", 64'(rd_log.size()), 64'd0);

    // Start during SEND (count=5) and start in the done cycle are both ignored.
    fill_mem(32'h0000_0400, 2);
    ready_mode = 1;
    do_dump(32'h0000_0400, 16'd2, 1'b1, 1'b1);
    check("poke_byte_total", 64'(acc_cnt), 64'd8);

    // Vector table.
    for (int v = 0; v < 5; v++) begin
      lat_cfg    = vecs[v].lat;
      ready_mode = vecs[v].rmode;
      fill_mem(vecs[v].base, int'(vecs[v].count));
      do_dump(vecs[v].base, vecs[v].count, 1'b0, 1'b0);
      check("vec_reads", 64'(rd_log.size()), 64'(vecs[v].exp_reads));
      check("vec_bytes", 64'(acc_cnt), 64'(vecs[v].exp_bytes));
      if (rd_log.size() > 0)
        check("vec_last_addr", 64'(rd_log[rd_log.size()-1]), 64'(vecs[v].exp_last_addr));
    end

    // Reset while byte 2 of word 0 is on the bus, then a stale rd_valid.
    fill_mem(32'h0002_0000, 3);
    lat_cfg    = 2;
    ready_mode = 0;
    clear_logs();
    model_push(32'h0002_0000, 16'd3);
    pulse_start(32'h0002_0000, 16'd3);
    n = 0;
    while (acc_cnt < 2 && n < 50) begin
      tick();
      n++;
    end
    check("rst_seq_two_bytes", 64'(acc_cnt), 64'd2);
    ready_mode = 2;
    tick();
    w = mem_read(32'h0002_0000);
    check("byte2_valid", 64'(bus.tx_valid), 64'd1);
    check("byte2_data", 64'(bus.tx_data), 64'(w[23:16]));
    tv  = txv_cnt;
    dc  = done_cnt;
    rl  = rd_log.size();
    rst = 1'b1;
    tick();
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_rd_req", 64'(bus.rd_req), 64'd0);
    check("mid_rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("mid_rst_tx_data", 64'(bus.tx_data), 64'd0);
    check("mid_rst_rd_addr", 64'(bus.rd_addr), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    ready_mode = 0;
    tick();
    stale_valid = 1'b1;
    tick();
    stale_valid = 1'b0;
    repeat (4) tick();
    check("post_rst_no_done", 64'(done_cnt), 64'(dc));
    check("stale_no_tx", 64'(txv_cnt), 64'(tv));
    check("stale_no_read", 64'(rd_log.size()), 64'(rl));
    check("post_rst_busy", 64'(bus.busy), 64'd0);
    check("post_rst_state", 64'(dbg_state), 64'(IDLE));
    do_dump(32'h0002_0000, 16'd2, 1'b0, 1'b0);

    // Randomized dumps against the model.
    for (int k = 0; k < 20; k++) begin
      r = $urandom;
      if ($urandom_range(0, 3) == 0) base = 32'hFFFF_FFF0 | (r & 32'h0000_000C);
      else                           base = r & 32'hFFFF_FFFC;
      cnt        = 16'($urandom_range(0, 6));
      lat_cfg    = 0;
      ready_mode = int'($urandom_range(0, 1));
      fill_mem(base, int'(cnt));
      do_dump(base, cnt, (cnt != 16'd0) && ($urandom_range(0, 1) == 1),
              $urandom_range(0, 1) == 1);
      check("rand_bytes", 64'(acc_cnt), 64'(4 * int'(cnt)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
